// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready flow control.
// Optional delivery statistics counters are built when HAMMING_DEC_STATS_EN is defined.
module hamming_secded_decoder #(
    parameter int DATA_W  = 4,
    parameter int COUNT_W = 16,
    localparam int R = (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 : 6,
    localparam int CW = DATA_W + R + 1,
    parameter logic [CW-1:0] INV_MASK = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CW-1:0]      codeword,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  msg,
    output logic [R-1:0]       syndrome,
    output logic               corrected,
    output logic               uncorrectable,
    input  logic               stats_clear,
    output logic [COUNT_W-1:0] corr_count,
    output logic [COUNT_W-1:0] uncorr_count
);

    localparam logic [R:0] CW_L = (R+1)'(CW);

    // Position of the k-th message bit: k-th index in 1..CW-1 that is not a power of two.
    function automatic int data_pos(int k);
        int n;
        int pos;
        n = 0;
        pos = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) pos = i;
                n++;
            end
        end
        return pos;
    endfunction

    logic              s1_valid_q;
    logic [CW-1:0]     w_q;
    logic [R-1:0]      s_q;
    logic              p_q;
    logic [CW-1:0]     w_d;
    logic [R-1:0]      s_d;
    logic              p_d;

    logic              s2_valid_q;
    logic [DATA_W-1:0] msg_q;
    logic [R-1:0]      syn_q;
    logic              corr_q;
    logic              unc_q;
    logic [CW-1:0]     wc;
    logic [DATA_W-1:0] msg_d;
    logic              corr_d;
    logic              unc_d;
    logic              in_range;
    logic              parity_bits_unused;

    logic s1_load;
    logic s2_load;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !reset;

    // Stage-1 inputs: unmasked working word, syndrome and overall parity.
    always_comb begin
        w_d = codeword ^ INV_MASK;
        s_d = '0;
        for (int i = 1; i < CW; i++) begin
            if (w_d[i]) s_d ^= R'(i);
        end
        p_d = ^w_d;
    end

    // Stage-1 register: captures a word whenever the slot is free or draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            w_q        <= '0;
            s_q        <= '0;
            p_q        <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                w_q <= w_d;
                s_q <= s_d;
                p_q <= p_d;
            end
        end
    end

    // Stage-2 inputs: classify, flip the located bit, and extract the message.
    always_comb begin
        in_range = {1'b0, s_q} < CW_L;
        wc       = w_q;
        if (p_q) begin
            for (int i = 1; i < CW; i++) begin
                if (s_q == R'(i)) wc[i] = ~wc[i];
            end
        end
        corr_d = p_q && in_range;
        unc_d  = (p_q && !in_range) || (!p_q && (s_q != '0));
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_ext
        localparam int POS = data_pos(k);
        assign msg_d[k] = wc[POS];
    end

    assign parity_bits_unused = ^wc;

    // Stage-2 register: result outputs hold while the sink stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            msg_q      <= '0;
            syn_q      <= '0;
            corr_q     <= 1'b0;
            unc_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                msg_q  <= msg_d;
                syn_q  <= s_q;
                corr_q <= corr_d;
                unc_q  <= unc_d;
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign msg           = msg_q;
    assign syndrome      = syn_q;
    assign corrected     = corr_q;
    assign uncorrectable = unc_q;

`ifdef HAMMING_DEC_STATS_EN
    logic [COUNT_W-1:0] corr_cnt_q;
    logic [COUNT_W-1:0] unc_cnt_q;
    logic               deliver;

    assign deliver = s2_valid_q && out_ready;

    // Saturating delivery counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else if (deliver) begin
            if (corr_q && !(&corr_cnt_q)) corr_cnt_q <= corr_cnt_q + COUNT_W'(1);
            if (unc_q && !(&unc_cnt_q))   unc_cnt_q  <= unc_cnt_q + COUNT_W'(1);
        end
    end

    assign corr_count   = corr_cnt_q;
    assign uncorr_count = unc_cnt_q;
`else
    logic stats_clear_unused;

    assign stats_clear_unused = stats_clear;
    assign corr_count         = '0;
    assign uncorr_count       = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Testbench for hamming_secded_decoder: directed table, stall/ordering,
// reset and statistics sequences, plus randomized traffic against a reference model.
module tb_hamming_secded_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int n_chk  = 0;
    int n_fail = 0;

    logic       a_iv, a_ir, a_ov, a_or, a_cor, a_unc, a_clr;
    logic [7:0] a_cw;
    logic [3:0] a_msg, a_cc, a_uc;
    logic [2:0] a_syn;

    logic        b_iv, b_ir, b_ov, b_or, b_cor, b_unc, b_clr;
    logic [7:0]  b_cw;
    logic [3:0]  b_msg;
    logic [2:0]  b_syn;
    logic [15:0] b_cc, b_uc;

    logic        c_iv, c_ir, c_ov, c_or, c_cor, c_unc, c_clr;
    logic [9:0]  c_cw;
    logic [4:0]  c_msg;
    logic [3:0]  c_syn;
    logic [15:0] c_cc, c_uc;

    hamming_secded_decoder #(.DATA_W(4), .COUNT_W(4)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir),
        .codeword(a_cw), .out_valid(a_ov), .out_ready(a_or), .msg(a_msg),
        .syndrome(a_syn), .corrected(a_cor), .uncorrectable(a_unc),
        .stats_clear(a_clr), .corr_count(a_cc), .uncorr_count(a_uc));

    hamming_secded_decoder #(.DATA_W(4), .INV_MASK(8'h15)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir),
        .codeword(b_cw), .out_valid(b_ov), .out_ready(b_or), .msg(b_msg),
        .syndrome(b_syn), .corrected(b_cor), .uncorrectable(b_unc),
        .stats_clear(b_clr), .corr_count(b_cc), .uncorr_count(b_uc));

    hamming_secded_decoder #(.DATA_W(5)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir),
        .codeword(c_cw), .out_valid(c_ov), .out_ready(c_or), .msg(c_msg),
        .syndrome(c_syn), .corrected(c_cor), .uncorrectable(c_unc),
        .stats_clear(c_clr), .corr_count(c_cc), .uncorr_count(c_uc));

    typedef struct {
        logic [63:0] msg;
        int          syn;
        bit          corr;
        bit          unc;
    } res_t;

    typedef struct {
        logic [7:0] cw;
        logic [3:0] msg;
        logic [2:0] syn;
        bit         corr;
        bit         unc;
    } vec_t;

    function automatic res_t model(int dw, logic [63:0] cwd, logic [63:0] mask);
        res_t r;
        int rr, cw, s, p, k;
        logic [63:0] w;
        rr = 0;
        while ((1 << rr) < dw + rr + 1) rr++;
        cw = dw + rr + 1;
        w = cwd ^ mask;
        s = 0;
        p = 0;
        for (int i = 0; i < cw; i++) begin
            if (w[i]) begin
                p = p ^ 1;
                s = s ^ i;
            end
        end
        r.syn  = s;
        r.corr = 0;
        r.unc  = 0;
        if (p == 1 && s < cw) begin
            r.corr = 1;
            if (s != 0) w[s] = ~w[s];
        end else if (p == 1 || s != 0) begin
            r.unc = 1;
        end
        r.msg = '0;
        k = 0;
        for (int i = 1; i < cw; i++) begin
            if ($countones(i) != 1) begin
                r.msg[k] = w[i];
                k++;
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    vec_t tbl[8];
    res_t q[$];
    res_t e;
    logic [7:0] bw[4];

    initial begin
        int idx, got, first_c, last_c, nacc, seen;
        bit a;

        tbl[0] = '{8'hAA, 4'b1011, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{8'h8A, 4'b1011, 3'd5, 1'b1, 1'b0};
        tbl[2] = '{8'hAB, 4'b1011, 3'd0, 1'b1, 1'b0};
        tbl[3] = '{8'hAC, 4'b1011, 3'd3, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 4'b0000, 3'd0, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 4'b1111, 3'd0, 1'b0, 1'b0};
        tbl[6] = '{8'h2A, 4'b1011, 3'd7, 1'b1, 1'b0};
        tbl[7] = '{8'hA9, 4'b1011, 3'd1, 1'b0, 1'b1};
        bw[0] = 8'hBF;
        bw[1] = 8'h15;
        bw[2] = 8'hEA;
        bw[3] = 8'h9F;

        reset = 1'b1;
        a_iv = 0; a_or = 1; a_clr = 0; a_cw = '0;
        b_iv = 0; b_or = 1; b_clr = 0; b_cw = '0;
        c_iv = 0; c_or = 1; c_clr = 0; c_cw = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_in_ready", a_ir, 0);
        chk("rst_msg", a_msg, 0);
        chk("rst_syn", a_syn, 0);
        chk("rst_flags", {a_cor, a_unc}, 0);
        chk("rst_counts", {a_cc, a_uc}, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", a_ir, 1);

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a_iv = 1;
            a_cw = tbl[v].cw;
            #1;
            chk($sformatf("t%0d_ready", v), a_ir, 1);
            @(posedge clk);
            @(negedge clk);
            a_iv = 0;
            #1;
            chk($sformatf("t%0d_lat1", v), a_ov, 0);
            @(negedge clk);
            #1;
            chk($sformatf("t%0d_lat2", v), a_ov, 1);
            chk($sformatf("t%0d_msg", v), a_msg, tbl[v].msg);
            chk($sformatf("t%0d_syn", v), a_syn, tbl[v].syn);
            chk($sformatf("t%0d_corr", v), a_cor, tbl[v].corr);
            chk($sformatf("t%0d_unc", v), a_unc, tbl[v].unc);
        end
        @(negedge clk);
`ifdef HAMMING_DEC_STATS_EN
        chk("tbl_corr_count", a_cc, 3);
        chk("tbl_uncorr_count", a_uc, 2);
`else
        chk("nostats_corr_count", a_cc, 0);
        chk("nostats_uncorr_count", a_uc, 0);
        a_clr = 1;
        @(negedge clk);
        a_clr = 0;
        chk("nostats_after_clr", {a_cc, a_uc}, 0);
`endif

        // Masked instance: single word, then stall/release ordering.
        @(negedge clk);
        b_iv = 1;
        b_cw = 8'h15;
        @(posedge clk);
        @(negedge clk);
        b_iv = 0;
        @(negedge clk);
        #1;
        chk("b_single_valid", b_ov, 1);
        chk("b_single_msg", b_msg, 0);
        chk("b_single_flags", {b_cor, b_unc}, 0);
        @(negedge clk);
        b_or = 0;
        b_iv = 1;
        b_cw = bw[0];
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            a = b_iv && b_ir;
            @(posedge clk);
            if (a) idx++;
            @(negedge clk);
            b_cw = bw[idx];
        end
        #1;
        e = model(4, bw[0], 8'h15);
        chk("b_accepted", idx, 2);
        chk("b_stall_in_ready", b_ir, 0);
        chk("b_stall_valid", b_ov, 1);
        chk("b_stall_msg", b_msg, e.msg);
        chk("b_stall_syn", b_syn, e.syn);
        b_or = 1;
        got = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            #1;
            a = b_iv && b_ir;
            if (b_ov && b_or) begin
                e = model(4, bw[got], 8'h15);
                chk($sformatf("b_out%0d_msg", got), b_msg, e.msg);
                chk($sformatf("b_out%0d_syn", got), b_syn, e.syn);
                chk($sformatf("b_out%0d_corr", got), b_cor, e.corr);
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            @(posedge clk);
            if (a) idx++;
            @(negedge clk);
            if (idx < 4) b_cw = bw[idx];
            else b_iv = 0;
        end
        chk("b_all_out", got, 4);
        chk("b_back_to_back", last_c - first_c, 3);
        b_iv = 0;

        // Randomized traffic with random backpressure on the DATA_W=5 instance.
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            c_iv = ($urandom_range(0, 3) != 0);
            c_cw = 10'($urandom);
            c_or = ($urandom_range(0, 3) != 0);
            #1;
            if (c_ov) chk("c_excl", c_cor & c_unc, 0);
            if (c_ov && c_or) begin
                if (q.size() == 0) begin
                    chk("c_extra_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("c_msg", c_msg, e.msg);
                    chk("c_syn", c_syn, e.syn);
                    chk("c_corr", c_cor, e.corr);
                    chk("c_unc", c_unc, e.unc);
                end
            end
            if (c_iv && c_ir) q.push_back(model(5, c_cw, 0));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c_iv = 0;
            c_or = 1;
            #1;
            if (c_ov) begin
                if (q.size() == 0) begin
                    chk("c_extra_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("c_drain_msg", c_msg, e.msg);
                    chk("c_drain_syn", c_syn, e.syn);
                end
            end
        end
        chk("c_drained", q.size(), 0);

`ifdef HAMMING_DEC_STATS_EN
        @(negedge clk);
        a_clr = 1;
        @(negedge clk);
        a_clr = 0;
        chk("clr_counts", {a_cc, a_uc}, 0);
        a_iv = 1;
        a_cw = 8'h8A;
        nacc = 0;
        for (int i = 0; i < 40 && nacc < 20; i++) begin
            #1;
            a = a_iv && a_ir;
            @(posedge clk);
            if (a) nacc++;
            @(negedge clk);
            if (nacc >= 20) a_iv = 0;
        end
        a_iv = 0;
        chk("sat_accepts", nacc, 20);
        repeat (4) @(negedge clk);
        chk("sat_corr_count", a_cc, 15);
        chk("sat_uncorr_count", a_uc, 0);
        a_iv = 1;
        @(posedge clk);
        @(negedge clk);
        a_iv = 0;
        @(negedge clk);
        #1;
        chk("clr_race_valid", a_ov && a_cor, 1);
        a_clr = 1;
        @(negedge clk);
        a_clr = 0;
        chk("clr_race_count", a_cc, 0);
`endif

        // Reset with two words in flight.
        @(negedge clk);
        a_iv = 1;
        a_cw = 8'h8A;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        a_iv = 0;
        reset = 1;
        #1;
        chk("midrst_in_ready", a_ir, 0);
        @(negedge clk);
        chk("midrst_out_valid", a_ov, 0);
        chk("midrst_counts", {a_cc, a_uc}, 0);
        reset = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_ov) seen++;
        end
        chk("midrst_no_partial", seen, 0);
        chk("midrst_counts_after", {a_cc, a_uc}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
